btn_debounce_pulse: RTL and testbench

//  Input-conditioning stage for the lab 6 datapath: synchronises a raw pushbutton/switch,

---
 rtl/lab6_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/btn_debounce_pulse.sv | 162 ++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lab6_pkg.sv
// Shared types and default timing constants for the lab 6 input-conditioning stage.
//   CLK_HZ           system clock frequency
//   DB_MS            debounce window in milliseconds
//   DB_CYCLES_DEF    default debounce window in clk cycles (5 ms)
//   LONG_CYCLES_DEF  default long-press hold time in clk cycles (1 s)
//   db_state_t       debounce FSM state encoding
package lab6_pkg;

  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int unsigned DB_MS           = 5;
  localparam int unsigned DB_CYCLES_DEF   = (CLK_HZ / 1000) * DB_MS;
  localparam int unsigned LONG_CYCLES_DEF = CLK_HZ;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   clk   in   system clock
//   rstn  in   asynchronous active-low reset, chain clears to 0
//   d     in   asynchronous input
//   q     out  synchronised output (last flop of the chain)
module sync_2ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift chain; bit 0 is the metastability-exposed flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioning: synchronise, debounce, and emit a clean level plus
// single-cycle press/release pulses. Optional long-press detection is built
// only when BTN_LONG_PRESS_EN is defined; otherwise long_press is tied to 0.
//   clk            in   system clock, rising edge
//   rstn           in   asynchronous active-low reset
//   btn_raw        in   asynchronous, bouncy button input
//   btn_level      out  debounced level, registered
//   press_pulse    out  one-cycle pulse on accepted 0->1
//   release_pulse  out  one-cycle pulse on accepted 1->0
//   long_press     out  one-cycle pulse after LONG_CYCLES held
module btn_debounce_pulse
  import lab6_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned    CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 1) begin : g_chk_db
    $error("DB_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_chk_long
    $error("LONG_CYCLES must be >= 1");
  end

  logic             btn_s;
  db_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, press_d, release_d;

  sync_2ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next state; the counter clears on every transition so it never wraps.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = REL_WAIT;
          cnt_d   = '0;
        end
      end
      REL_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs track the state register.
  always_comb begin
    level_d   = 1'b0;
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = (state_d == HELD) || (state_d == REL_WAIT);
    press_d   = (state == PRESS_WAIT) && (state_d == HELD);
    release_d = (state == REL_WAIT) && (state_d == IDLE);
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              long_d;

  // Hold counter: cleared on accepted press, saturates at LONG_CYCLES so the
  // pulse fires once; bounces inside the release window do not clear it.
  always_comb begin
    hold_cnt_d = hold_cnt;
    long_d     = 1'b0;
    if ((state == PRESS_WAIT) && (state_d == HELD)) begin
      hold_cnt_d = '0;
    end else if (((state == HELD) || (state == REL_WAIT)) && (hold_cnt != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt + HOLD_W'(1);
      long_d     = (hold_cnt == HOLD_LAST) && (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      hold_cnt   <= hold_cnt_d;
      long_press <= long_d;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse (SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=16).
// Stimulus pushes expected pulse events (kind, cycle); a negedge monitor pops and
// compares whenever the DUT raises a pulse, and checks level changes coincide with pulses.
module tb_btn_debounce_pulse;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  // Raw change driven at negedge of cycle N is first sampled at edge N+1,
  // so the accepted pulse appears after edge N+1+SYNC_STAGES+DB_CYCLES.
  localparam int LAT  = 7;
  localparam int LONG = 16;

  logic clk;
  logic rstn;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int   cyc;
  int   n_pass;
  int   n_total;
  logic prev_level;
  ev_t  exp_q[$];

  btn_debounce_pulse #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .LONG_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(ev_kind_t k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_eq(string name, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // Pop the next expected event and compare kind, cycle and level.
  task automatic sb_check(ev_kind_t k);
    ev_t  e;
    logic lvl_exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got pulse at cycle %0d expected none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      lvl_exp = (k != EV_RELEASE);
      if (e.kind == k && e.cyc == cyc && btn_level == lvl_exp) n_pass++;
      else $display("FAIL event_%s: got %s at cycle %0d level %b expected %s at cycle %0d level %b",
                    e.kind.name(), k.name(), cyc, btn_level, e.kind.name(), e.cyc, lvl_exp);
    end
  endtask

  task automatic at(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare against the scoreboard whenever an output pulse is presented.
  always @(negedge clk) begin
    if (rstn) begin
      if (press_pulse || release_pulse) begin
        n_total++;
        if (press_pulse && release_pulse)
          $display("FAIL both_pulses: press=1 release=1 expected not both at cycle %0d", cyc);
        else n_pass++;
      end
      if (press_pulse)   sb_check(EV_PRESS);
      if (release_pulse) sb_check(EV_RELEASE);
      if (long_press)    sb_check(EV_LONG);
      if (btn_level != prev_level) begin
        n_total++;
        if ((btn_level && press_pulse) || (!btn_level && release_pulse)) n_pass++;
        else $display("FAIL level_change: level went %b->%b without matching pulse at cycle %0d",
                      prev_level, btn_level, cyc);
      end
    end
    prev_level = btn_level;
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    prev_level = 1'b0;
    btn_raw    = 1'b0;
    rstn       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_level",   btn_level,     1'b0);
    check_eq("rst_press",   press_pulse,   1'b0);
    check_eq("rst_release", release_pulse, 1'b0);
    check_eq("rst_long",    long_press,    1'b0);
    rstn = 1'b1;

    // 1: clean press then clean release
    at(10); btn_raw = 1'b1; push(EV_PRESS, 10 + LAT);
    at(22); btn_raw = 1'b0; push(EV_RELEASE, 22 + LAT);

    // 2: bouncy press (3 high, 2 low, then high)
    at(40); btn_raw = 1'b1;
    at(43); btn_raw = 1'b0;
    at(45); btn_raw = 1'b1; push(EV_PRESS, 45 + LAT);

    // 3: bouncy release (2 low, 1 high, then low)
    at(54); btn_raw = 1'b0;
    at(56); btn_raw = 1'b1;
    at(57); btn_raw = 1'b0; push(EV_RELEASE, 57 + LAT);

    // 4: reset during PRESS_WAIT with cnt=2, raw stays high through reset
    at(75); btn_raw = 1'b1;
    at(80);
    #2 rstn = 1'b0;
    #1;
    check_eq("midrst_level",   btn_level,     1'b0);
    check_eq("midrst_press",   press_pulse,   1'b0);
    check_eq("midrst_release", release_pulse, 1'b0);
    check_eq("midrst_long",    long_press,    1'b0);
    at(84); rstn = 1'b1; push(EV_PRESS, 84 + LAT);

    // Reset while HELD clears the level asynchronously with no release pulse
    at(100);
    check_eq("held_level", btn_level, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_eq("heldrst_level",   btn_level,     1'b0);
    check_eq("heldrst_release", release_pulse, 1'b0);
    btn_raw = 1'b0;
    at(103); rstn = 1'b1;

    // 5/6: 40-cycle hold (long press when enabled), then 10-cycle hold (never)
    at(115); btn_raw = 1'b1; push(EV_PRESS, 115 + LAT);
`ifdef BTN_LONG_PRESS_EN
    push(EV_LONG, 115 + LAT + LONG);
`endif
    at(155); btn_raw = 1'b0; push(EV_RELEASE, 155 + LAT);
    at(175); btn_raw = 1'b1; push(EV_PRESS, 175 + LAT);
    at(185); btn_raw = 1'b0; push(EV_RELEASE, 185 + LAT);

    at(230);
    check_eq("final_level", btn_level, 1'b0);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_%s: got no pulse expected one at cycle %0d", e.kind.name(), e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
